// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, op encodings, FSM states and op decode helpers
package mem_access_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int ADDR_W     = 32;

  // Bus wait limit in BUSY cycles before the access is abandoned
  localparam logic [7:0] TIMEOUT_CYC = 8'd255;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  // Access size of an op; unknown codes decode as no access (NOP)
  function automatic size_t op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      MEM_LW, MEM_SW:          return SZ_WORD;
      default:                 return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data bus request/completion interface
interface mem_access_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - load lane select and sign/zero extension
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [1:0]       addr,
  input  logic [3:0]       op,
  input  logic [REG_W-1:0] rdata,
  output logic [REG_W-1:0] data
);

  logic [REG_W-1:0] shifted;

  // Shift the addressed lane down to bit 0, then extend per op
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    data    = rdata;
    case (op)
      MEM_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: data = {24'd0, shifted[7:0]};
      MEM_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: data bus access FSM and WB registers
module mem_access
  import mem_access_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [REG_W-1:0]      mem_wdata,
  input  logic [3:0]            mem_op,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [REG_W-1:0]      mem_sdata,
  input  logic                  flush,
  mem_access_if.master          dbus,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic                  stallreq,
  output logic                  exc_misalign,
  output logic                  exc_buserr
);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic                  wb_wreg_q, wb_wreg_d;
  logic [REG_W-1:0]      wb_wdata_q, wb_wdata_d;
  logic                  exc_misalign_q, exc_misalign_d;
  logic                  exc_buserr_q, exc_buserr_d;
  logic                  stall_c;

  size_t                 size;
  logic                  is_mem, is_store, misaligned, busy;
  logic [3:0]            be_c;
  logic [REG_W-1:0]      bus_wdata_c, load_data;

  assign size       = op_size(mem_op);
  assign is_mem     = (size != SZ_NONE);
  assign is_store   = op_is_store(mem_op);
  assign misaligned = ((size == SZ_HALF) && mem_addr[0]) ||
                      ((size == SZ_WORD) && (mem_addr[1:0] != 2'b00));

  mem_access_load_align load_align (
    .addr  (mem_addr[1:0]),
    .op    (mem_op),
    .rdata (dbus.dbus_rdata),
    .data  (load_data)
  );

  // Little-endian byte enables and lane-replicated store data
  always_comb begin
    be_c        = 4'b0000;
    bus_wdata_c = mem_sdata;
    case (size)
      SZ_BYTE: begin
        be_c        = 4'b0001 << mem_addr[1:0];
        bus_wdata_c = {4{mem_sdata[7:0]}};
      end
      SZ_HALF: begin
        be_c        = 4'b0011 << mem_addr[1:0];
        bus_wdata_c = {2{mem_sdata[15:0]}};
      end
      SZ_WORD: be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Upstream holds op/addr/sdata stable while stalled, so bus fields stay stable until ack
  assign busy            = (state_q == ST_BUSY) && !rst;
  assign dbus.dbus_req   = busy;
  assign dbus.dbus_we    = busy && is_store;
  assign dbus.dbus_addr  = busy ? {mem_addr[31:2], 2'b00} : '0;
  assign dbus.dbus_be    = busy ? be_c : 4'b0000;
  assign dbus.dbus_wdata = busy ? bus_wdata_c : '0;

  // Next state, counter, WB payload and exception pulses; defaults are a WB bubble
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wb_wd_d        = '0;
    wb_wreg_d      = 1'b0;
    wb_wdata_d     = '0;
    exc_misalign_d = 1'b0;
    exc_buserr_d   = 1'b0;
    stall_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!is_mem) begin
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg;
          wb_wdata_d = mem_wdata;
        end else if (misaligned) begin
          exc_misalign_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = 8'd0;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (dbus.dbus_ack) begin
          state_d = ST_IDLE;
          if (!is_store) begin
            wb_wd_d    = mem_wd;
            wb_wreg_d  = mem_wreg;
            wb_wdata_d = load_data;
          end
        end else if (cnt_q == TIMEOUT_LIMIT - 8'd1) begin
          state_d      = ST_IDLE;
          exc_buserr_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and WB/exception registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      wb_wd_q        <= '0;
      wb_wreg_q      <= 1'b0;
      wb_wdata_q     <= '0;
      exc_misalign_q <= 1'b0;
      exc_buserr_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_wd_q        <= wb_wd_d;
      wb_wreg_q      <= wb_wreg_d;
      wb_wdata_q     <= wb_wdata_d;
      exc_misalign_q <= exc_misalign_d;
      exc_buserr_q   <= exc_buserr_d;
    end
  end

  assign stallreq     = stall_c && !rst;
  assign wb_wd        = wb_wd_q;
  assign wb_wreg      = wb_wreg_q;
  assign wb_wdata     = wb_wdata_q;
  assign exc_misalign = exc_misalign_q;
  assign exc_buserr   = exc_buserr_q;

endmodule
